// File: rtl/mult_arbiter.sv
// Two-requester front end that time-shares one combinational 8x8 signed
// multiplier; an IDLE/MUL/DONE sequencer holds each result until it is consumed.

module booth_mult8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [8:0]  bx;
  logic [15:0] a_ext;
  logic [15:0] pp;
  logic [15:0] acc;

  // Radix-4 Booth: four signed digits in {-2..+2}, each scaling the
  // sign-extended multiplicand before accumulation at weight 4^i.
  always_comb begin
    bx    = {b, 1'b0};
    a_ext = {{8{a[7]}}, a};
    acc   = '0;
    pp    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      unique case (bx[2*i +: 3])
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext << 1;
        3'b100:         pp = -(a_ext << 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      acc = acc + (pp << (2*i));
    end
    p = acc;
  end
endmodule

module mult_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_p,
  output logic        rsp_id,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t      state, state_nxt;
  logic        grant;
  logic        lrg;
  logic        accept;
  logic [7:0]  op_a, op_b;
  logic        op_id;
  logic [15:0] product;

  always_comb begin
    grant = 1'b0;
    if (req0_valid && !req1_valid)      grant = 1'b0;
    else if (req1_valid && !req0_valid) grant = 1'b1;
    else if (req0_valid && req1_valid)  grant = (FIXED_PRIO != 0) ? 1'b0 : ~lrg;
  end

  assign accept = req0_ready | req1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = MUL;
      MUL:     state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is qualified by rst_n so it falls the instant reset asserts.
  always_comb begin
    req0_ready = rst_n && (state == IDLE) && !grant && req0_valid;
    req1_ready = rst_n && (state == IDLE) &&  grant && req1_valid;
    rsp_valid  = (state == DONE);
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lrg    <= 1'b1;
      op_a   <= '0;
      op_b   <= '0;
      op_id  <= 1'b0;
      rsp_p  <= '0;
      rsp_id <= 1'b0;
    end else begin
      if (accept) begin
        lrg   <= grant;
        op_a  <= grant ? req1_a : req0_a;
        op_b  <= grant ? req1_b : req0_b;
        op_id <= grant;
      end
      if (state == MUL) begin
        rsp_p  <= product;
        rsp_id <= op_id;
      end
    end
  end

  booth_mult8 u_mult (
    .a (op_a),
    .b (op_b),
    .p (product)
  );
endmodule
